// File: rtl/cla_share_arbiter_pkg.sv
// Shared FPU adder definitions: adder width, operand bundle and response states.
package cla_share_arbiter_pkg;

  localparam int MANT_W = 33;

  // One requester's operation as presented to the shared adder.
  typedef struct packed {
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic              cin;
    logic              sub;
  } add_req_t;

  // Occupancy of the one-entry response buffer.
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  // Ceiling log2 with a floor of 1, so a 2-requester arbiter still has a 1-bit ID.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// Parallel-prefix carry-lookahead adder shared by the FPU datapaths.
module cla_adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  // Kogge-Stone prefix over generate/propagate, then fold carry-in into every bit.
  always_comb begin
    logic [W-1:0] p;
    logic [W-1:0] gk;
    logic [W-1:0] pk;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    p  = a ^ b;
    gk = a & b;
    pk = p;
    for (int d = 1; d < W; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < W; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = gk[i] | (pk[i] & cin);
    end
    sum  = p ^ carry[W-1:0];
    cout = carry[W];
  end

endmodule

// File: rtl/cla_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: first active request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Scan N slots starting at the pointer; the first hit wins when enabled.
  always_comb begin
    int k;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
    any = found & en;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/cla_share_arbiter.sv
// One CLA shared by NUM_REQ requesters with a registered, ID-tagged response slot.
module cla_share_arbiter
  import cla_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*MANT_W-1:0] req_a,
  input  logic [NUM_REQ*MANT_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [MANT_W-1:0]         rsp_sum,
  output logic                      rsp_cout,
  output logic [ID_W-1:0]           rsp_id
);

  rsp_state_t        state, state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic              can_issue;
  logic              transfer;
  add_req_t          win_req;
  logic [MANT_W-1:0] b_cond;
  logic              cin_cond;
  logic [MANT_W-1:0] add_sum;
  logic              add_cout;

  assign can_issue = !rsp_valid || rsp_ready;
  assign transfer  = win_any;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (can_issue && !rst),
    .grant (req_ready),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Steer the winner's operands; subtraction becomes A + ~B + 1.
  always_comb begin
    win_req.a   = req_a[int'(win_idx)*MANT_W +: MANT_W];
    win_req.b   = req_b[int'(win_idx)*MANT_W +: MANT_W];
    win_req.cin = req_cin[win_idx];
    win_req.sub = req_sub[win_idx];
    b_cond      = win_req.sub ? ~win_req.b : win_req.b;
    cin_cond    = win_req.sub ? 1'b1 : win_req.cin;
  end

  cla_adder #(
    .W (MANT_W)
  ) u_cla (
    .a    (win_req.a),
    .b    (b_cond),
    .cin  (cin_cond),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Response-buffer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RSP_EMPTY;
    else     state <= state_next;
  end

  // Fill on any transfer; drain only when the consumer takes it and nothing replaces it.
  always_comb begin
    state_next = state;
    case (state)
      RSP_EMPTY: if (transfer) state_next = RSP_FULL;
      RSP_FULL:  if (!transfer && rsp_ready) state_next = RSP_EMPTY;
      default:   state_next = RSP_EMPTY;
    endcase
  end

  // The buffer is valid exactly while full.
  always_comb begin
    rsp_valid = (state == RSP_FULL);
  end

  // Capture the adder result and winner ID on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else if (transfer) begin
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
      rsp_id   <= win_idx;
    end
  end

  // Priority rotates to just past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      if (win_idx == ID_W'(NUM_REQ - 1)) ptr <= '0;
      else                               ptr <= win_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed self-checking bench for the shared CLA arbiter.
module tb_cla_share_arbiter;

  localparam int N = 4;
  localparam int W = 33;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;

  int total_checks;
  int failed_checks;

  cla_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
    req_cin[k]      = cin;
    req_sub[k]      = sub;
    req_valid[k]    = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    assert (observed === expected)
    else begin
      failed_checks++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag, input logic [W-1:0] sum, input logic cout, input logic [1:0] id);
    checkOutput({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    checkOutput({tag, "_sum"},   64'(rsp_sum),   64'(sum));
    checkOutput({tag, "_cout"},  64'(rsp_cout),  64'(cout));
    checkOutput({tag, "_id"},    64'(rsp_id),    64'(id));
  endtask

  initial begin
    logic [N-1:0] exp_grant;
    total_checks  = 0;
    failed_checks = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;

    // Reset: outputs cleared and ready held low even with valid requests.
    stepClk();
    stepClk();
    req_valid = 4'b1111;
    #1;
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_sum",   64'(rsp_sum),   64'd0);
    checkOutput("rst_cout",  64'(rsp_cout),  64'd0);
    checkOutput("rst_id",    64'(rsp_id),    64'd0);
    rst       = 1'b0;
    req_valid = '0;
    stepClk();
    checkOutput("idle_valid", 64'(rsp_valid), 64'd0);

    // Single add from requester 0: 5 + 3.
    applyStimulus(0, 33'd5, 33'd3, 1'b0, 1'b0);
    #1;
    checkOutput("add_grant", 64'(req_ready), 64'b0001);
    stepClk();
    req_valid = '0;
    #1;
    checkRsp("add", 33'd8, 1'b0, 2'd0);
    stepClk();
    checkOutput("drain_valid", 64'(rsp_valid), 64'd0);

    // Subtract 3 - 5 from requester 2 (pointer is now 1).
    applyStimulus(2, 33'd3, 33'd5, 1'b0, 1'b1);
    #1;
    checkOutput("sub1_grant", 64'(req_ready), 64'b0100);
    stepClk();
    // Back-to-back: 5 - 3 with cin=1 that must be ignored.
    applyStimulus(2, 33'd5, 33'd3, 1'b1, 1'b1);
    #1;
    checkRsp("sub1", 33'h1_FFFF_FFFE, 1'b0, 2'd2);
    checkOutput("sub2_grant", 64'(req_ready), 64'b0100);
    stepClk();
    req_valid = '0;
    #1;
    checkRsp("sub2", 33'd2, 1'b1, 2'd2);
    stepClk();

    // Overflow cases on requester 3.
    applyStimulus(3, 33'h1_FFFF_FFFF, 33'd0, 1'b1, 1'b0);
    #1;
    checkOutput("ovf1_grant", 64'(req_ready), 64'b1000);
    stepClk();
    applyStimulus(3, 33'h1_FFFF_FFFF, 33'd1, 1'b0, 1'b0);
    #1;
    checkRsp("ovf1", 33'd0, 1'b1, 2'd3);
    stepClk();
    req_valid = '0;
    #1;
    checkRsp("ovf2", 33'd0, 1'b1, 2'd3);
    stepClk();

    // Round robin: requester k computes 16k + k = 17k, pointer starts at 0.
    for (int k = 0; k < N; k++) applyStimulus(k, 33'(16 * k), 33'(k), 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_grant = '0;
      exp_grant[i % N] = 1'b1;
      checkOutput($sformatf("rr%0d_grant", i), 64'(req_ready), 64'(exp_grant));
      stepClk();
      checkRsp($sformatf("rr%0d", i), 33'(17 * (i % N)), 1'b0, 2'(i % N));
    end

    // Backpressure: all requests still valid, consumer stalls three cycles.
    rsp_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp%0d_ready", i), 64'(req_ready), 64'd0);
      checkRsp($sformatf("bp%0d", i), 33'd0, 1'b0, 2'd0);
      stepClk();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_grant", 64'(req_ready), 64'b0010);
    stepClk();
    checkRsp("bp_release", 33'd17, 1'b0, 2'd1);

    // Reset while full with requester 1 pending.
    req_valid = 4'b0010;
    rst       = 1'b1;
    #1;
    checkOutput("mrst_ready_during", 64'(req_ready), 64'd0);
    stepClk();
    checkOutput("mrst_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mrst_ready", 64'(req_ready), 64'd0);
    checkOutput("mrst_sum",   64'(rsp_sum),   64'd0);
    rst = 1'b0;
    applyStimulus(0, 33'd7, 33'd1, 1'b0, 1'b0);
    #1;
    checkOutput("mrst_grant0", 64'(req_ready), 64'b0001);
    stepClk();
    req_valid[0] = 1'b0;
    #1;
    checkRsp("mrst_r0", 33'd8, 1'b0, 2'd0);
    checkOutput("mrst_grant1", 64'(req_ready), 64'b0010);
    stepClk();
    req_valid = '0;
    #1;
    checkRsp("mrst_r1", 33'd17, 1'b0, 2'd1);
    stepClk();
    checkOutput("final_valid", 64'(rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/cla_share_arbiter.md
Name: cla_share_arbiter

Overview:
- Shares one 33-bit carry-lookahead adder (CLA) among NUM_REQ requesters, e.g. mantissa align/add and exponent-difference paths in the FPU.
- Round-robin arbitration with valid/ready per requester.
- Adder result is registered into a one-entry response buffer tagged with the winner's ID.
- Throughput is one operation per cycle when the response side keeps up.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*33  operand A, requester k at bits [33k+32:33k].
- req_b  in  NUM_REQ*33  operand B, same packing.
- req_cin  in  NUM_REQ  carry-in per requester.
- req_sub  in  NUM_REQ  1 = compute A - B (two's complement).
- rsp_valid  out  1  result buffer holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  33  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_id  out  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - Round-robin pointer = 0, meaning requester 0 has highest priority.
  - req_ready is forced to 0 during reset.
- An in-flight result is discarded on reset; no response is ever produced for it.
- can_issue = !rsp_valid | rsp_ready.
- Grant (combinational):
  - The first requester with req_valid=1, searching from the pointer upward modulo NUM_REQ, wins when can_issue=1.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - req_ready never depends on rsp_sum or other data, only on valids, the pointer, rsp_valid and rsp_ready.
- Operand conditioning for the winner:
  - req_sub=0: adder inputs are A, B, req_cin.
  - req_sub=1: adder inputs are A, ~B, cin=1; req_cin is ignored.
- Transfer (req_valid & req_ready at a clk edge):
  - rsp_sum, rsp_cout and rsp_id load from the adder output and winner index.
  - rsp_valid=1 on the next cycle. Latency is exactly 1 cycle.
  - Pointer = (winner+1) mod NUM_REQ.
- Pointer holds when no transfer occurs.
- Response:
  - rsp_valid & rsp_ready with no new transfer: rsp_valid clears.
  - rsp_valid & rsp_ready with a simultaneous transfer: the buffer reloads, rsp_valid stays 1, giving back-to-back operation.
  - rsp_valid=1 and rsp_ready=0: all req_ready=0 (stall), and rsp_* hold stable.
- Requester rules:
  - A requester holds req_valid and operands stable until accepted.
  - The arbiter does not depend on this (no combinational path from rsp to req data).
- Arithmetic is modulo 2^33; cout is the adder's bit-33 carry.
- Widths: A=0x1_FFFF_FFFF plus B=1 gives sum=0, cout=1.
- Fairness: any continuously asserted request is granted within NUM_REQ transfers.
- States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY to FULL on a transfer.
  - FULL to EMPTY on rsp_ready with no transfer.
  - FULL to FULL on a transfer with rsp_ready, or on a stall.

Decomposition:
- Shared fpu package holds:
  - MANT_W=33, the adder width constant.
  - Function clog2.
  - Typedef add_req_t with fields a, b, cin, sub.
- One sub-module, rr_arbiter:
  - Inputs: req vector, pointer, enable.
  - Output: one-hot grant plus encoded index.
- The adder itself is the team's existing CLA module, instantiated once.

Test Plan:
- Single requester: req0 A=5, B=3, sub=0, cin=0, rsp_ready=1 -> next cycle rsp_valid=1, sum=8, cout=0, id=0.
- Subtract: req2 A=3, B=5, sub=1 -> sum=0x1_FFFF_FFFE, cout=0, id=2; then A=5, B=3, sub=1 -> sum=2, cout=1.
- Overflow: A=0x1_FFFF_FFFF, B=0, cin=1 -> sum=0, cout=1.
- Round-robin: all 4 valid continuously, rsp_ready=1 -> grants and rsp_id sequence 0,1,2,3,0, one per cycle, with no bubbles.
- Backpressure: hold rsp_ready=0 for 3 cycles after a result -> all req_ready=0, rsp_* stable; raise rsp_ready -> the pending request is granted the same cycle and the new result appears next cycle.
- Reset mid-operation: assert rst while rsp_valid=1 and req1 valid -> next cycle rsp_valid=0, req_ready=0; after release, req0 (if valid) wins before req1.
